io_mem_responder: RTL and testbench



---
 rtl/io_mem_responder_pkg.sv | 32 +++
 rtl/io_lane_align.sv | 54 +++++
 rtl/io_mem_responder.sv | 151 +++++++++++++++
 tb/tb_io_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_mem_responder_pkg.sv
// rtl/io_mem_responder_pkg.sv - shared io bus codes, responder state encodings and request record
package io_mem_responder_pkg;

    localparam int DATA_W = 32;

    // io_byte_size codes, shared with sys_bus
    localparam logic [1:0] IO_BSIZE_WORD = 2'd0;
    localparam logic [1:0] IO_BSIZE_BYTE = 2'd1;
    localparam logic [1:0] IO_BSIZE_HALF = 2'd2;
    localparam logic [1:0] IO_BSIZE_RSVD = 2'd3;

    // Responder state encodings, shared with sys_bus
    localparam logic [1:0] IO_RSP_IDLE = 2'd0;
    localparam logic [1:0] IO_RSP_WAIT = 2'd1;
    localparam logic [1:0] IO_RSP_BEAT = 2'd2;
    localparam logic [1:0] IO_RSP_RESP = 2'd3;

    // Request captured at accept; addr and beats_left advance during a burst
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              write;
        logic              both;
        logic              burst;
        logic [1:0]        size;
        logic [2:0]        beats_left;
    } req_t;

    function automatic logic size_reserved(input logic [1:0] size);
        return size == IO_BSIZE_RSVD;
    endfunction

endpackage

// File: rtl/io_lane_align.sv
// rtl/io_lane_align.sv - byte-lane steering for io_mem_responder array accesses
//
// Purely combinational.
//   addr_lo   : byte offset within the word
//   size      : io_byte_size code of the access
//   wdata     : initiator write data (right-justified)
//   old_word  : current array word at the access index
//   mask      : byte lanes written by this access
//   wlanes    : write data replicated onto every lane it may land on
//   rdata     : selected lanes, right-justified and zero-extended
//   misalign  : half on an odd address, or word not on a word boundary
module io_lane_align
    import io_mem_responder_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] old_word,
    output logic [3:0]        mask,
    output logic [DATA_W-1:0] wlanes,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign
);

    always_comb begin
        mask     = 4'b0000;
        wlanes   = '0;
        rdata    = '0;
        misalign = 1'b0;
        case (size)
            IO_BSIZE_BYTE: begin
                mask   = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
                rdata  = {24'h0, old_word[{addr_lo, 3'b000} +: 8]};
            end
            IO_BSIZE_HALF: begin
                mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{wdata[15:0]}};
                rdata    = {16'h0, old_word[{addr_lo[1], 4'b0000} +: 16]};
                misalign = addr_lo[0];
            end
            IO_BSIZE_WORD: begin
                mask     = 4'b1111;
                wlanes   = wdata;
                rdata    = old_word;
                misalign = addr_lo != 2'b00;
            end
            default: begin
                // reserved size: no lanes; flagged as an error by the caller
            end
        endcase
    end

endmodule

// File: rtl/io_mem_responder.sv
// rtl/io_mem_responder.sv - io bus target servicing single and burst accesses from a word array
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   io_addr         : byte address, sampled at accept
//   io_read/io_write: request levels
//   burst/burst_size: burst request and beats-1, sampled at accept
//   read_ready      : initiator can take a burst beat this cycle
//   io_wdata        : write data for the current beat
//   io_byte_size    : 0=word, 1=byte, 2=half, 3=reserved
//   io_rdata        : read data, valid with io_ready
//   io_ready        : one-cycle pulse per completed beat
//   io_err          : error flag, valid with io_ready
//   busy            : state is not IDLE
module io_mem_responder
    import io_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] io_addr,
    input  logic              io_read,
    input  logic              io_write,
    input  logic              burst,
    input  logic [2:0]        burst_size,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic [1:0]        io_byte_size,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ready,
    output logic              io_err,
    output logic              busy
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state;
    req_t              req_q;
    logic [3:0]        wait_cnt;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [DATA_W-1:0] offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic [3:0]        mask;
    logic [DATA_W-1:0] wlanes;
    logic [DATA_W-1:0] rd_ext;
    logic              misalign;
    logic              fire;
    logic              beat_err;
    logic              mem_we;

    // Addresses below the base wrap to huge offsets, so one unsigned compare covers both ends
    assign offset   = req_q.addr - ADDR_BASE;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = offset[IDX_W+1:2];
    assign rd_word  = mem[idx];

    io_lane_align u_lane_align (
        .addr_lo  (req_q.addr[1:0]),
        .size     (req_q.size),
        .wdata    (io_wdata),
        .old_word (rd_word),
        .mask     (mask),
        .wlanes   (wlanes),
        .rdata    (rd_ext),
        .misalign (misalign)
    );

    // Single-beat transfers complete regardless of read_ready
    assign fire     = (state == IO_RSP_BEAT) && (!req_q.burst || read_ready);
    assign beat_err = req_q.both || size_reserved(req_q.size) || misalign || !in_range;
    assign mem_we   = fire && req_q.write && !beat_err;
    assign busy     = state != IO_RSP_IDLE;

    // Array is not reset; state reset keeps mem_we low, so an abandoned write never commits
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IO_RSP_IDLE;
            req_q    <= '0;
            wait_cnt <= 4'd0;
            io_ready <= 1'b0;
            io_err   <= 1'b0;
            io_rdata <= '0;
        end else begin
            case (state)
                IO_RSP_IDLE: begin
                    if (io_read || io_write) begin
                        req_q.addr       <= io_addr;
                        req_q.write      <= io_write && !io_read;
                        req_q.both       <= io_write && io_read;
                        req_q.burst      <= burst;
                        req_q.size       <= burst ? IO_BSIZE_WORD : io_byte_size;
                        req_q.beats_left <= burst ? burst_size : 3'd0;
                        wait_cnt         <= WAIT_LOAD;
                        state            <= (WAIT_CYCLES > 0) ? IO_RSP_WAIT : IO_RSP_BEAT;
                    end
                end
                IO_RSP_WAIT: begin
                    if (!io_read && !io_write) begin
                        state <= IO_RSP_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= IO_RSP_BEAT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                IO_RSP_BEAT: begin
                    if (fire) begin
                        io_ready <= 1'b1;
                        io_err   <= beat_err;
                        io_rdata <= (req_q.write || beat_err) ? '0 : rd_ext;
                        if (req_q.beats_left != 3'd0) begin
                            req_q.beats_left <= req_q.beats_left - 3'd1;
                            req_q.addr       <= req_q.addr + 32'd4;
                        end else begin
                            state <= IO_RSP_RESP;
                        end
                    end else begin
                        io_ready <= 1'b0;
                        io_err   <= 1'b0;
                    end
                end
                default: begin
                    // RESP: final beat's pulse ends; request lines still show the old transaction
                    io_ready <= 1'b0;
                    io_err   <= 1'b0;
                    state    <= IO_RSP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_mem_responder.sv
// tb/tb_io_mem_responder.sv - directed self-checking bench for io_mem_responder
module tb_io_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          WAITC = 2;
    localparam logic [1:0]  SZ_WORD = 2'd0;
    localparam logic [1:0]  SZ_BYTE = 2'd1;
    localparam logic [1:0]  SZ_HALF = 2'd2;
    localparam logic [1:0]  SZ_RSVD = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] io_addr = '0;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic        burst = 1'b0;
    logic [2:0]  burst_size = '0;
    logic        read_ready = 1'b0;
    logic [31:0] io_wdata = '0;
    logic [1:0]  io_byte_size = '0;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic        io_err;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl [int unsigned];
    logic [32:0] expq [$];

    logic [31:0] bd [8];
    logic        be [8];
    int          bt [8];

    always #5 clk = ~clk;

    io_mem_responder #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_addr      (io_addr),
        .io_read      (io_read),
        .io_write     (io_write),
        .burst        (burst),
        .burst_size   (burst_size),
        .read_ready   (read_ready),
        .io_wdata     (io_wdata),
        .io_byte_size (io_byte_size),
        .io_rdata     (io_rdata),
        .io_ready     (io_ready),
        .io_err       (io_err),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One beat's outcome {err, rdata} from the bus rules, applied to a sparse word model
    function automatic logic [32:0] model_beat(input logic [31:0] addr, input bit wr, input bit both,
                                               input logic [1:0] size, input logic [31:0] wdata);
        longint      a;
        longint      lim;
        bit          err;
        int unsigned widx;
        logic [31:0] word;
        int          sh;
        a   = addr;
        lim = longint'(BASE) + 4 * DEPTH - 1;
        err = both || size == SZ_RSVD || a < longint'(BASE) || a > lim
              || (size == SZ_HALF && a % 2 != 0) || (size == SZ_WORD && a % 4 != 0);
        if (err) return {1'b1, 32'h0};
        widx = int'((a - longint'(BASE)) / 4);
        word = mdl.exists(widx) ? mdl[widx] : 32'h0;
        sh   = int'(8 * (a % 4));
        if (wr) begin
            if (size == SZ_WORD) word = wdata;
            else if (size == SZ_BYTE) word = (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            else word = (word & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            mdl[widx] = word;
            return {1'b0, 32'h0};
        end
        if (size == SZ_BYTE) return {1'b0, (word >> sh) & 32'hFF};
        if (size == SZ_HALF) return {1'b0, (word >> sh) & 32'hFFFF};
        return {1'b0, word};
    endfunction

    // Scoreboard: every io_ready beat must match the next modelled beat
    always @(negedge clk) begin
        if (rst && io_ready) begin
            if (expq.size() == 0) begin
                check("spurious_ready", 32'(io_ready), 32'd0);
            end else begin
                logic [32:0] e;
                e = expq.pop_front();
                check("beat_err", 32'(io_err), 32'(e[32]));
                check("beat_rdata", io_rdata, e[31:0]);
            end
        end
    end

    task automatic start(input logic [31:0] addr, input bit rd, input bit wr, input logic [1:0] size,
                         input logic [31:0] wdata, input bit bst, input logic [2:0] bsz, input bit push);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_wait", 32'(busy), 32'd0);
        io_addr = addr; io_read = rd; io_write = wr; io_byte_size = size;
        io_wdata = wdata; burst = bst; burst_size = bsz;
        if (push) begin
            for (int i = 0; i < (bst ? int'(bsz) + 1 : 1); i++) begin
                expq.push_back(model_beat(addr + 32'(4 * i), wr && !rd, rd && wr,
                                          bst ? SZ_WORD : size, wdata));
            end
        end
    endtask

    task automatic single(input logic [31:0] addr, input bit rd, input bit wr, input logic [1:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdat, output logic err);
        int k;
        start(addr, rd, wr, size, wdata, 1'b0, 3'd0, 1'b1);
        read_ready = 1'b0;
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        k = 0;
        while (!io_ready && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("single_latency", 32'(k), 32'(WAITC + 1));
        rdat = io_rdata;
        err  = io_err;
        io_read = 1'b0; io_write = 1'b0;
    endtask

    task automatic burst_rd(input logic [31:0] addr, input logic [2:0] bsz, input int drop_after);
        int n;
        int c;
        int drop_c;
        start(addr, 1'b1, 1'b0, SZ_WORD, 32'h0, 1'b1, bsz, 1'b1);
        read_ready = 1'b1;
        @(posedge clk); #1;
        n = 0; c = 0; drop_c = -10;
        while (n < int'(bsz) + 1 && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (io_ready) begin
                bd[n] = io_rdata; be[n] = io_err; bt[n] = c;
                n++;
                if (n == drop_after) begin
                    read_ready = 1'b0;
                    drop_c = c;
                end
            end
            if (!read_ready && c == drop_c + 2) read_ready = 1'b1;
        end
        check("burst_beat_count", 32'(n), 32'(int'(bsz) + 1));
        io_read = 1'b0; burst = 1'b0;
    endtask

    logic [31:0] rd_v;
    logic        er_v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_io_ready", 32'(io_ready), 32'd0);
        check("rst_io_err", 32'(io_err), 32'd0);
        check("rst_io_rdata", io_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // word write then read back
        single(32'h8000_0010, 0, 1, SZ_WORD, 32'hDEAD_BEEF, rd_v, er_v);
        single(32'h8000_0010, 1, 0, SZ_WORD, 32'h0, rd_v, er_v);
        check("word_read_lit", rd_v, 32'hDEAD_BEEF);
        check("word_read_err", 32'(er_v), 32'd0);

        // byte merge and half extract
        single(32'h8000_0010, 0, 1, SZ_WORD, 32'h1122_3344, rd_v, er_v);
        single(32'h8000_0011, 0, 1, SZ_BYTE, 32'h0000_00AB, rd_v, er_v);
        single(32'h8000_0010, 1, 0, SZ_WORD, 32'h0, rd_v, er_v);
        check("byte_merge_lit", rd_v, 32'h1122_AB44);
        single(32'h8000_0012, 1, 0, SZ_HALF, 32'h0, rd_v, er_v);
        check("half_read_lit", rd_v, 32'h0000_1122);
        single(32'h8000_0013, 1, 0, SZ_BYTE, 32'h0, rd_v, er_v);
        check("byte_read_lit", rd_v, 32'h0000_0011);

        // burst with read_ready dropped for two cycles after beat 2
        for (int i = 0; i < 4; i++)
            single(32'h8000_0020 + 32'(4 * i), 0, 1, SZ_WORD, 32'(i + 1), rd_v, er_v);
        burst_rd(32'h8000_0020, 3'd3, 2);
        for (int i = 0; i < 4; i++) check("burst_data_lit", bd[i], 32'(i + 1));
        check("burst_t0", 32'(bt[0]), 32'd3);
        check("burst_t1", 32'(bt[1]), 32'd4);
        check("burst_t2_gap", 32'(bt[2]), 32'd7);
        check("burst_t3", 32'(bt[3]), 32'd8);

        // burst crossing the top of the array
        single(32'h8000_0FF8, 0, 1, SZ_WORD, 32'hA5A5_0001, rd_v, er_v);
        single(32'h8000_0FFC, 0, 1, SZ_WORD, 32'hA5A5_0002, rd_v, er_v);
        burst_rd(32'h8000_0FF8, 3'd3, 0);
        check("top_beat1_data", bd[1], 32'hA5A5_0002);
        check("top_beat1_err", 32'(be[1]), 32'd0);
        check("top_beat2_err", 32'(be[2]), 32'd1);
        check("top_beat3_rdata", bd[3], 32'd0);

        // error cases
        single(32'h7FFF_FFFC, 1, 0, SZ_WORD, 32'h0, rd_v, er_v);
        check("below_base_err", 32'(er_v), 32'd1);
        check("below_base_rdata", rd_v, 32'd0);
        single(32'h8000_0001, 1, 0, SZ_HALF, 32'h0, rd_v, er_v);
        check("misalign_half_err", 32'(er_v), 32'd1);
        single(32'h8000_0010, 0, 1, SZ_RSVD, 32'hFFFF_FFFF, rd_v, er_v);
        check("rsvd_size_err", 32'(er_v), 32'd1);
        single(32'h8000_0010, 1, 1, SZ_WORD, 32'hFFFF_FFFF, rd_v, er_v);
        check("both_err", 32'(er_v), 32'd1);
        single(32'h8000_1000, 0, 1, SZ_WORD, 32'hFFFF_FFFF, rd_v, er_v);
        check("above_top_err", 32'(er_v), 32'd1);
        single(32'h8000_0010, 1, 0, SZ_WORD, 32'h0, rd_v, er_v);
        check("unchanged_after_err", rd_v, 32'h1122_AB44);

        // write abandoned during WAIT
        single(32'h8000_0040, 0, 1, SZ_WORD, 32'hCAFE_F00D, rd_v, er_v);
        start(32'h8000_0040, 0, 1, SZ_WORD, 32'h1234_5678, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #1;
        io_write = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        single(32'h8000_0040, 1, 0, SZ_WORD, 32'h0, rd_v, er_v);
        check("abort_unchanged", rd_v, 32'hCAFE_F00D);

        // asynchronous reset while in BEAT with io_ready high
        start(32'h8000_0020, 1'b1, 1'b0, SZ_WORD, 32'h0, 1'b1, 3'd3, 1'b0);
        read_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 30 && !io_ready; k++) begin
            @(posedge clk); #1;
        end
        read_ready = 1'b0;
        check("pre_rst_ready", 32'(io_ready), 32'd1);
        check("pre_rst_rdata", io_rdata, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ready", 32'(io_ready), 32'd0);
        check("async_rst_err", 32'(io_err), 32'd0);
        check("async_rst_rdata", io_rdata, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        io_read = 1'b0; burst = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        single(32'h8000_0024, 1, 0, SZ_WORD, 32'h0, rd_v, er_v);
        check("mem_survives_rst", rd_v, 32'd2);

        repeat (3) @(posedge clk);
        check("missed_beats", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
